// File: rtl/button_conditioner.sv
// Purpose : N-channel push-button front end: synchroniser, debounce, press/release pulses, chord detect.
// Latency : a clean btn_n edge changes pressed SYNC_STAGES+DEBOUNCE_CYCLES edges after it is driven;
//           the pulses are registered together with pressed.
// Backpressure: none; every output is a registered level or a single-cycle pulse.
// Ports:
//   Clk, Reset    : rising-edge clock, asynchronous active-high reset
//   btn_n[N]      : raw active-low buttons, asynchronous to Clk
//   pressed[N]    : debounced level, 1 = held
//   press_pulse   : 1-cycle pulse on pressed rise
//   release_pulse : 1-cycle pulse on pressed fall (masked chord channels are silent while locked)
//   chord_active  : all CHORD_MASK channels held for at least CHORD_HOLD_CYCLES
//   chord_pulse   : 1-cycle pulse on chord_active rise
module button_conditioner #(
  parameter int             N                 = 2,
  parameter int             SYNC_STAGES       = 2,
  parameter int             DEBOUNCE_CYCLES   = 4,
  parameter logic [N-1:0]   CHORD_MASK        = N'(2'b11),
  parameter int             CHORD_HOLD_CYCLES = 3
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [N-1:0] btn_n,
  output logic [N-1:0] pressed,
  output logic [N-1:0] press_pulse,
  output logic [N-1:0] release_pulse,
  output logic         chord_active,
  output logic         chord_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(CHORD_HOLD_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD      = HW'(CHORD_HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(CHORD_HOLD_CYCLES - 1);
  localparam bit            CHORD_EN  = (CHORD_MASK != '0);

  logic [SYNC_STAGES-1:0][N-1:0] sync_q, sync_d;
  logic [N-1:0]                  deb_q, deb_d;   // accepted level, active-low
  logic [N-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [N-1:0]                  press_pulse_q, press_pulse_d;
  logic [N-1:0]                  release_pulse_q, release_pulse_d;
  logic [HW-1:0]                 hcnt_q, hcnt_d;
  logic                          chord_active_q, chord_active_d;
  logic                          chord_pulse_q, chord_pulse_d;
  logic                          lock_q, lock_d;

  logic [N-1:0] s;
  logic [N-1:0] pressed_now, pressed_nxt;
  logic         held;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = btn_n;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
    s = sync_q[SYNC_STAGES-1];

    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < N; i++) begin
      if (s[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        deb_d[i] = s[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end

    pressed_now   = ~deb_q;
    pressed_nxt   = ~deb_d;
    press_pulse_d = pressed_nxt & ~pressed_now;

    // Chord qualification looks at the registered pressed vector, so it
    // trails the debounced levels by one cycle.
    held           = CHORD_EN && (&(pressed_now | ~CHORD_MASK));
    hcnt_d         = hcnt_q;
    chord_active_d = chord_active_q;
    chord_pulse_d  = 1'b0;
    lock_d         = lock_q;
    if (!held) begin
      hcnt_d         = '0;
      chord_active_d = 1'b0;
    end else if (hcnt_q != HOLD) begin
      hcnt_d = hcnt_q + HW'(1);
      if (hcnt_q == HOLD_LAST) begin
        chord_active_d = 1'b1;
        chord_pulse_d  = 1'b1;
      end
    end
    if ((pressed_now & CHORD_MASK) == '0) begin
      lock_d = 1'b0;
    end
    if (chord_pulse_d) begin
      lock_d = 1'b1;
    end

    // Mask with the lock value that is visible alongside the pulse, so a
    // release landing on the very edge the chord fires is also swallowed.
    release_pulse_d = ~pressed_nxt & pressed_now & ~(lock_d ? CHORD_MASK : '0);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync_q          <= '1;
      deb_q           <= '1;
      cnt_q           <= '0;
      press_pulse_q   <= '0;
      release_pulse_q <= '0;
      hcnt_q          <= '0;
      chord_active_q  <= 1'b0;
      chord_pulse_q   <= 1'b0;
      lock_q          <= 1'b0;
    end else begin
      sync_q          <= sync_d;
      deb_q           <= deb_d;
      cnt_q           <= cnt_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      hcnt_q          <= hcnt_d;
      chord_active_q  <= chord_active_d;
      chord_pulse_q   <= chord_pulse_d;
      lock_q          <= lock_d;
    end
  end

  assign pressed       = ~deb_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign chord_active  = chord_active_q;
  assign chord_pulse   = chord_pulse_q;

endmodule
